// File: rtl/uart_mon_pkg.sv
// Shared types and frame constants for the UART receive monitor.
package uart_mon_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_e;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_mon_fifo.sv
// Small synchronous FIFO. The head entry is always visible on head_data, and
// reads as zero while the FIFO is empty. Extra-MSB pointers separate full from empty.
module uart_mon_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head_data
);

   localparam int AW    = $clog2(DEPTH);
   localparam int PTR_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_ok    = pop && !empty;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign push_ok   = push && (!full || pop_ok);
   assign head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance for accepted pushes and pops.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset because the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver for observing uart0_tx. Decoded bytes are queued in a small
// FIFO behind a valid/ready port. Framing errors and overflow are single-cycle pulses.
module uart_rx_monitor
   import uart_mon_pkg::*;
#(
   parameter int CLK_DIV          = 868,
   parameter int FIFO_DEPTH       = 4,
   parameter int simulation_delay = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] m_axis_data,
   output logic       m_axis_valid,
   input  logic       m_axis_ready,
   output logic       frame_err,
   output logic       overflow,
   output logic       busy
);

   localparam int              CNT_W    = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV - 1);
   localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

   // The RTL carries no assignment delays and handles a single stop bit.
   // These two configuration values are tied off here so they stay visible.
   logic unused_cfg;
   assign unused_cfg = (simulation_delay != 0) ^ (UART_STOP_BITS != 1);

   logic       rxd_meta_q, rxd_s_q, rxd_prev_q;
   state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0] idx_q, idx_d;
   logic [7:0] shreg_q, shreg_d;
   logic       frame_err_q, frame_err_d;
   logic       overflow_q, overflow_d;
   logic       push;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fall;
   logic       cnt_zero;

   assign fall         = rxd_prev_q && !rxd_s_q;
   assign cnt_zero     = (cnt_q == '0);
   assign m_axis_valid = !fifo_empty;
   assign pop          = m_axis_valid && m_axis_ready;
   assign busy         = (state_q != IDLE);
   assign frame_err    = frame_err_q;
   assign overflow     = overflow_q;
   // A completed byte is lost only when no slot is free and nothing leaves this cycle.
   assign overflow_d   = push && fifo_full && !pop;

   // Two-flop synchronizer plus a delayed copy for falling-edge detection; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
         rxd_prev_q <= rxd_s_q;
      end
   end

   // Frame FSM: mid-bit sampling driven by a down-counter reloaded once per bit.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shreg_d     = shreg_q;
      push        = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (fall) begin
               cnt_d   = CNT_HALF;
               state_d = START;
            end
         end
         START: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rxd_s_q) begin
               state_d = IDLE;
            end else begin
               cnt_d   = CNT_FULL;
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               shreg_d = {rxd_s_q, shreg_q[7:1]};
               cnt_d   = CNT_FULL;
               if (idx_q == IDX_LAST) state_d = STOP;
               else                   idx_d   = idx_q + 3'd1;
            end
         end
         STOP: begin
            if (!cnt_zero) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (rxd_s_q) begin
               push    = 1'b1;
               state_d = IDLE;
            end else begin
               frame_err_d = 1'b1;
               state_d     = BREAK;
            end
         end
         BREAK: begin
            // Wait for the line to return high so a held-low line yields one error only.
            if (rxd_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   // Shift register is pure data; a byte is pushed only after a complete frame.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

   uart_mon_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (shreg_q),
      .pop       (pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head_data (m_axis_data)
   );

endmodule
